// File: rtl/nl_vc_alloc_arb_pkg.sv
// Shared router helpers: one-hot to binary and lowest-set-bit picker.
package nl_vc_alloc_arb_pkg;

   // Widest vector the helpers accept; callers zero-extend into it.
   localparam int unsigned max_vec_w = 32;

   // Isolate the lowest set bit (all-zero in, all-zero out).
   function automatic logic [max_vec_w-1:0] lsb_pick(input logic [max_vec_w-1:0] v);
      return v & (~v + 32'd1);
   endfunction

   // Index of the set bit in a one-hot vector (0 for all-zero).
   function automatic int unsigned oh2bin(input logic [max_vec_w-1:0] oh);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < max_vec_w; i++) begin
         if (oh[i]) r = i;
      end
      return r;
   endfunction

endpackage

// File: rtl/nl_vc_alloc_arb_rr.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping.
module nl_rr_arb
   import nl_vc_alloc_arb_pkg::*;
#(
   parameter int unsigned n     = 4,
   parameter int unsigned ptr_w = $clog2(n)
) (
   input  logic [n-1:0]     req,
   input  logic [ptr_w-1:0] ptr,
   output logic [n-1:0]     winner_c
);

   logic [n-1:0] mask;
   logic [n-1:0] masked;

   // Prefer requesters at or above ptr; fall back to the lowest one when none qualify.
   always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < n; i++) begin
         mask[i] = (i >= 32'(ptr));
      end
      masked   = req & mask;
      winner_c = (masked != '0) ? n'(lsb_pick(32'(masked))) : n'(lsb_pick(32'(req)));
   end

endmodule

// File: rtl/nl_vc_alloc_arb.sv
// Output-port VC allocator: one requester and one free VC per cycle, registered grant.
module nl_vc_alloc_arb
   import nl_vc_alloc_arb_pkg::*;
#(
   parameter int unsigned num_requesters = 4,
   parameter int unsigned num_vcs_global = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [num_requesters-1:0] req,
   input  logic [num_vcs_global-1:0] vc_alloc_status,
   output logic [num_requesters-1:0] gnt,
   output logic [num_vcs_global-1:0] gnt_vc,
   output logic [num_vcs_global-1:0] vc_allocated
);

   localparam int unsigned ptr_w = $clog2(num_requesters);

   logic [ptr_w-1:0]          rr_ptr;
   logic [ptr_w-1:0]          ptr_next;
   logic [num_requesters-1:0] eligible_req;
   logic [num_requesters-1:0] winner;
   logic [num_vcs_global-1:0] eligible_vc;
   logic [num_vcs_global-1:0] vc_pick;
   logic                      decide;
   int unsigned               win_idx;

   // Mask out the grant/VC currently on the outputs: their sources have not reacted yet.
   assign eligible_req = req & ~gnt;
   assign eligible_vc  = vc_alloc_status & ~vc_allocated;

   nl_rr_arb #(
      .n     (num_requesters),
      .ptr_w (ptr_w)
   ) u_rr_arb (
      .req      (eligible_req),
      .ptr      (rr_ptr),
      .winner_c (winner)
   );

   // Decision, VC choice and the pointer value that follows the winner.
   always_comb begin
      decide   = 1'b0;
      vc_pick  = '0;
      win_idx  = 0;
      ptr_next = rr_ptr;
      decide   = (eligible_req != '0) && (eligible_vc != '0);
      vc_pick  = num_vcs_global'(lsb_pick(32'(eligible_vc)));
      win_idx  = oh2bin(32'(winner));
      ptr_next = (win_idx == num_requesters - 1) ? '0 : ptr_w'(win_idx + 1);
   end

   // Register the decision; no decision means an all-zero output cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt    <= '0;
         gnt_vc <= '0;
         rr_ptr <= '0;
      end else if (decide) begin
         gnt    <= winner;
         gnt_vc <= vc_pick;
         rr_ptr <= ptr_next;
      end else begin
         gnt    <= '0;
         gnt_vc <= '0;
      end
   end

   // The VC handed out is exactly the one consumed from the free pool.
   assign vc_allocated = gnt_vc;

endmodule
